// File: rtl/clock_monitor_pkg.sv
// ============================================================================
// Module      : clock_monitor_pkg
// Description : Shared state encoding and default timing constants for the
//               divided-clock monitor and its companion divider.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package clock_monitor_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    LOST     = 2'd3
  } cm_state_t;

  localparam int c_DEF_EXPECTED_PERIOD = 4;
  localparam int c_DEF_LOCK_COUNT      = 4;

  // True when a measured period lies within +/- tol of the nominal period.
  function automatic logic within_tol(input int unsigned meas,
                                      input int unsigned nominal,
                                      input int unsigned tol);
    int unsigned diff;
    diff = (meas > nominal) ? (meas - nominal) : (nominal - meas);
    return (diff <= tol);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_monitor_edge_sync.sv
// ============================================================================
// Module      : clock_monitor_edge_sync
// Description : Two-flop synchronizer plus edge-history flop producing
//               single-cycle rise/fall strobes for an asynchronous input.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module clock_monitor_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/clock_monitor.sv
// ============================================================================
// Module      : clock_monitor
// Description : Measures a divided clock's period in master cycles and tracks
//               lock/loss against an expected ratio.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int EXPECTED_PERIOD = c_DEF_EXPECTED_PERIOD,
  parameter int TOLERANCE       = 0,
  parameter int LOCK_COUNT      = c_DEF_LOCK_COUNT,
  parameter int CNT_W           = 8,
  parameter int ERR_W           = 8
) (
  input  logic             Master_Clock_In,
  input  logic             Reset,
  input  logic             Clock_In,
  output logic             Rise_Strobe,
  output logic             Fall_Strobe,
  output logic [CNT_W-1:0] Period_Count,
  output logic             Period_Valid,
  output logic             Locked,
  output logic             Loss_Strobe,
  output logic [ERR_W-1:0] Error_Count
);

  localparam int              c_GC_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(2 * EXPECTED_PERIOD + TOLERANCE);
  localparam logic [c_GC_W-1:0] c_LOCK   = c_GC_W'(LOCK_COUNT);

  logic              w_rise;
  logic              w_fall;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_armed;
  logic [CNT_W:0]    w_meas;
  logic              w_timeout;
  logic [CNT_W-1:0]  r_pcount;
  logic              r_pvalid;
  logic              r_pgood;
  cm_state_t         r_state;
  cm_state_t         w_state_nxt;
  logic [c_GC_W-1:0] r_gc;
  logic [c_GC_W-1:0] w_gc_nxt;
  logic [c_GC_W-1:0] w_gc_inc;
  logic              w_loss;
  logic              r_loss;
  logic [ERR_W-1:0]  r_err;

  clock_monitor_edge_sync u_sync (
    .clk    (Master_Clock_In),
    .rst    (Reset),
    .i_async(Clock_In),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_meas    = {1'b0, r_cnt} + 1'b1;
  // A rise in the threshold cycle wins: the period is measured, not timed out.
  assign w_timeout = r_armed & ~w_rise & (r_cnt == c_TIMEOUT);

  always_ff @(posedge Master_Clock_In or posedge Reset) begin
    if (Reset) begin
      r_cnt    <= '0;
      r_armed  <= 1'b0;
      r_pcount <= '0;
      r_pvalid <= 1'b0;
      r_pgood  <= 1'b0;
    end else begin
      r_pvalid <= 1'b0;
      if (w_rise) begin
        r_cnt   <= '0;
        r_armed <= 1'b1;
        if (r_armed) begin
          r_pcount <= (&r_cnt) ? r_cnt : w_meas[CNT_W-1:0];
          r_pvalid <= 1'b1;
          r_pgood  <= within_tol(32'(w_meas), EXPECTED_PERIOD, TOLERANCE);
        end
      end else begin
        if (!(&r_cnt)) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_timeout) begin
          r_armed <= 1'b0;
        end
      end
    end
  end

  assign w_gc_inc = r_gc + 1'b1;

  // Measurements act on the FSM from the registered Period_Valid cycle;
  // a timeout can never coincide with one, so it is consumed directly.
  always_comb begin
    w_state_nxt = r_state;
    w_gc_nxt    = r_gc;
    w_loss      = 1'b0;
    unique case (r_state)
      UNLOCKED: begin
        if (w_rise) begin
          w_state_nxt = ACQUIRE;
          w_gc_nxt    = '0;
        end
      end
      ACQUIRE: begin
        if (w_timeout) begin
          w_state_nxt = UNLOCKED;
        end else if (r_pvalid) begin
          if (!r_pgood) begin
            w_gc_nxt = '0;
          end else begin
            w_gc_nxt = w_gc_inc;
            if (w_gc_inc == c_LOCK) begin
              w_state_nxt = LOCKED;
            end
          end
        end
      end
      LOCKED: begin
        if (w_timeout || (r_pvalid && !r_pgood)) begin
          w_state_nxt = LOST;
          w_loss      = 1'b1;
        end
      end
      LOST: begin
        if (w_timeout || !r_armed) begin
          w_state_nxt = UNLOCKED;
        end else if (r_pvalid && r_pgood) begin
          w_state_nxt = ACQUIRE;
          w_gc_nxt    = c_GC_W'(1);
        end
      end
      default: begin
        w_state_nxt = UNLOCKED;
      end
    endcase
  end

  always_ff @(posedge Master_Clock_In or posedge Reset) begin
    if (Reset) begin
      r_state <= UNLOCKED;
      r_gc    <= '0;
      r_loss  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gc    <= w_gc_nxt;
      r_loss  <= w_loss;
      if (w_loss && !(&r_err)) begin
        r_err <= r_err + 1'b1;
      end
    end
  end

  assign Rise_Strobe  = w_rise;
  assign Fall_Strobe  = w_fall;
  assign Period_Count = r_pcount;
  assign Period_Valid = r_pvalid;
  assign Locked       = (r_state == LOCKED);
  assign Loss_Strobe  = r_loss;
  assign Error_Count  = r_err;

endmodule

`default_nettype wire
